keypad_event_encoder: RTL

Parametrised, debounced keypad encoder for the timer-input path. It takes N_KEYS raw button levels and synchronises and debounces them. Each new key press becomes exactly one binary key code, delivered to the timer/digit logic over a valid/ack handshake, with overflow reporting. It replaces the purely combinational key encoder and adds press-edge detection, debounce and event buffering.

---
 rtl/keypad_event_encoder_if.sv | 12 +
 rtl/keypad_event_encoder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/keypad_event_encoder_if.sv
// rtl/keypad_event_encoder_if.sv - key event handshake bundle (code/dv/ovf out, ack back)
interface keypad_event_encoder_if #(
  parameter int CODE_W = 4
);
  logic [CODE_W-1:0] code;
  logic              dv;
  logic              ovf;
  logic              ack;

  modport master (output code, output dv, output ovf, input ack);
  modport slave  (input code, input dv, input ovf, output ack);
endinterface

// File: rtl/keypad_event_encoder.sv
// rtl/keypad_event_encoder.sv - synchronised, debounced keypad press encoder with valid/ack event output
// Optional KEYENC_MULTI_ERR_EN: multi-key press loads the all-ones error code.
module keypad_event_encoder #(
  parameter int N_KEYS    = 10,
  parameter int CODE_W    = 4,
  parameter int DB_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [N_KEYS-1:0]      keys,
  keypad_event_encoder_if.master evt
);

  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [7:0] DB_TH = 8'(DB_CYCLES);

  logic [N_KEYS-1:0] sync1, sync2, sync2_prev, stable;
  logic [7:0]        cnt, cnt_next;
  logic              changed, accept;
  logic [CODE_W-1:0] sel, load_code;
  logic              multi;
  state_t            state, state_next;
  logic              fire;
  logic [CODE_W-1:0] code_q;
  logic              dv_q, ovf_q;

  // A new value of sync2 restarts the run length at one edge seen.
  always_comb begin
    changed = (sync2 != sync2_prev);
    if (changed)
      cnt_next = 8'd1;
    else if (cnt == 8'hFF)
      cnt_next = cnt;
    else
      cnt_next = cnt + 8'd1;
    accept = (sync2 != stable) && (cnt_next >= DB_TH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= '0;
      sync2      <= '0;
      sync2_prev <= '0;
      stable     <= '0;
      cnt        <= '0;
    end else begin
      sync1      <= keys;
      sync2      <= sync1;
      sync2_prev <= sync2;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (accept) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt_next;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < N_KEYS; i++)
      if (stable[i]) sel = CODE_W'(i);
    multi = |(stable & (stable - N_KEYS'(1)));
`ifdef KEYENC_MULTI_ERR_EN
    load_code = multi ? {CODE_W{1'b1}} : sel;
`else
    load_code = sel;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (stable != '0) state_next = HELD;
      HELD:    if (stable == '0) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fire = (state == IDLE) && (stable != '0) && en;
  end

  // An ack coinciding with a new event frees the slot, so the event loads instead of overflowing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= '0;
      dv_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (fire) begin
      if (!dv_q || evt.ack) begin
        code_q <= load_code;
        dv_q   <= 1'b1;
        if (dv_q) ovf_q <= 1'b0;
      end else begin
        ovf_q <= 1'b1;
      end
    end else if (dv_q && evt.ack) begin
      dv_q  <= 1'b0;
      ovf_q <= 1'b0;
    end
  end

  assign evt.code = code_q;
  assign evt.dv   = dv_q;
  assign evt.ovf  = ovf_q;

  logic unused_ok;
  assign unused_ok = multi;

endmodule
